// File: rtl/packet_snap_cutter_pkg.sv
// Shared definitions for the packet snap cutter: tuser field offsets,
// FSM encoding and byte-lane helper functions.
package packet_snap_cutter_pkg;

  localparam int LEN_LO  = 0;
  localparam int LEN_HI  = 15;
  localparam int LEN_F   = LEN_HI - LEN_LO + 1;
  localparam int SRC_LO  = 16;
  localparam int MAX_BPB = 128;

  typedef enum logic [1:0] {
    SOP,
    PASS,
    DROP
  } state_t;

  // Low n lanes set, never more than bpb lanes.
  function automatic logic [MAX_BPB-1:0] keep_mask(
    input logic [31:0] n,
    input int          bpb
  );
    logic [MAX_BPB-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BPB; i++)
      if (i < bpb && 32'(i) < n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [15:0] popcount(
    input logic [MAX_BPB-1:0] v
  );
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < MAX_BPB; i++)
      c = c + 16'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/snap_cutter_stats.sv
// Packet, cut and dropped-byte counters; a clear beats any
// increment arriving in the same cycle.
module snap_cutter_stats
  import packet_snap_cutter_pkg::*;
(
  input  logic        Bus2IP_Clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc_in,
  input  logic        inc_cut,
  input  logic [31:0] add_bytes,
  output logic [31:0] pkt_in_cnt,
  output logic [31:0] pkt_cut_cnt,
  output logic [31:0] bytes_dropped_cnt
);

  always_ff @(posedge Bus2IP_Clk) begin
    if (rst || clr) begin
      pkt_in_cnt        <= '0;
      pkt_cut_cnt       <= '0;
      bytes_dropped_cnt <= '0;
    end else begin
      if (inc_in)
        pkt_in_cnt <= pkt_in_cnt + 32'd1;
      if (inc_cut) begin
        pkt_cut_cnt       <= pkt_cut_cnt + 32'd1;
        bytes_dropped_cnt <= bytes_dropped_cnt + add_bytes;
      end
    end
  end

endmodule

// File: rtl/packet_snap_cutter.sv
// Per-channel byte-granular packet truncation with a one-deep
// output register slice and drop statistics.
module packet_snap_cutter
  import packet_snap_cutter_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_CH             = 4,
  parameter int TRUNC_FLAG_BIT     = 32,
  parameter int LEN_WIDTH          = 16
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  input  logic                            cut_en,
  input  logic [NUM_CH*LEN_WIDTH-1:0]     snap_len,
  input  logic                            clr_stats,
  output logic [31:0]                     pkt_in_cnt,
  output logic [31:0]                     pkt_cut_cnt,
  output logic [31:0]                     bytes_dropped_cnt
);

  localparam int BPB = C_AXIS_DATA_WIDTH / 8;

  state_t state;

  logic [LEN_WIDTH-1:0] s_lat;
  logic [LEN_WIDTH-1:0] len_lat;
  logic [LEN_WIDTH-1:0] bc;
  logic [LEN_WIDTH-1:0] snap_sel;
  logic [LEN_WIDTH-1:0] s_eff;
  logic [LEN_WIDTH-1:0] len_eff;
  logic [LEN_WIDTH-1:0] bc_eff;
  logic [LEN_WIDTH-1:0] beat_bytes;
  logic [LEN_WIDTH-1:0] rem;
  logic [LEN_WIDTH:0]   reach;
  logic                 is_sop;
  logic                 accept;
  logic                 trunc_pkt;
  logic                 cut;
  logic [BPB-1:0]       cut_keep;

  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_o;

  assign is_sop = (state == SOP);
  assign s_axis_tready = (state == DROP) | ~m_axis_tvalid
                       | m_axis_tready;
  assign accept = s_axis_tvalid & s_axis_tready;

  // Lowest matching channel wins.
  always_comb begin
    snap_sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (s_axis_tuser[SRC_LO + 2*i])
        snap_sel = snap_len[i*LEN_WIDTH +: LEN_WIDTH];
    if (!cut_en) snap_sel = '0;
  end

  assign s_eff   = is_sop ? snap_sel : s_lat;
  assign len_eff = is_sop
                 ? LEN_WIDTH'(s_axis_tuser[LEN_HI:LEN_LO])
                 : len_lat;
  assign bc_eff  = is_sop ? '0 : bc;

  assign beat_bytes =
    LEN_WIDTH'(popcount(MAX_BPB'(s_axis_tkeep)));
  assign reach = {1'b0, bc_eff} + {1'b0, beat_bytes};

  assign trunc_pkt = (s_eff != '0) && (s_eff < len_eff);
  assign cut       = trunc_pkt && (reach >= {1'b0, s_eff});
  assign rem       = s_eff - bc_eff;
  assign cut_keep  = BPB'(keep_mask(32'(rem), BPB));

  always_comb begin
    tuser_o = s_axis_tuser;
    if (is_sop && trunc_pkt) begin
      tuser_o[LEN_HI:LEN_LO]  = LEN_F'(s_eff);
      tuser_o[TRUNC_FLAG_BIT] = 1'b1;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state         <= SOP;
      s_lat         <= '0;
      len_lat       <= '0;
      bc            <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
    end else begin
      if (m_axis_tready)
        m_axis_tvalid <= 1'b0;
      if (accept) begin
        if (is_sop) begin
          s_lat   <= s_eff;
          len_lat <= len_eff;
        end
        bc <= reach[LEN_WIDTH-1:0];
        if (state == DROP) begin
          if (s_axis_tlast) state <= SOP;
        end else begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= s_axis_tdata;
          m_axis_tkeep  <= cut ? cut_keep : s_axis_tkeep;
          m_axis_tlast  <= cut | s_axis_tlast;
          m_axis_tuser  <= tuser_o;
          if (s_axis_tlast)
            state <= SOP;
          else if (cut)
            state <= DROP;
          else
            state <= PASS;
        end
      end
    end
  end

  snap_cutter_stats u_stats (
    .Bus2IP_Clk        (axi_aclk),
    .rst               (axi_reset),
    .clr               (clr_stats),
    .inc_in            (accept & is_sop),
    .inc_cut           (accept & (state != DROP) & cut),
    .add_bytes         (32'(len_eff - s_eff)),
    .pkt_in_cnt        (pkt_in_cnt),
    .pkt_cut_cnt       (pkt_cut_cnt),
    .bytes_dropped_cnt (bytes_dropped_cnt)
  );

endmodule

// File: tb/tb_packet_snap_cutter.sv
// Bench for packet_snap_cutter: directed cases plus randomized
// traffic scored against a packet-level reference model.
module tb_packet_snap_cutter;

  localparam int DW  = 256;
  localparam int UW  = 128;
  localparam int NCH = 4;
  localparam int LW  = 16;
  localparam int BPB = DW / 8;

  logic              axi_aclk = 1'b0;
  logic              axi_reset;
  logic [DW-1:0]     s_axis_tdata;
  logic [BPB-1:0]    s_axis_tkeep;
  logic [UW-1:0]     s_axis_tuser;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic [DW-1:0]     m_axis_tdata;
  logic [BPB-1:0]    m_axis_tkeep;
  logic [UW-1:0]     m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              cut_en;
  logic [NCH*LW-1:0] snap_len;
  logic              clr_stats;
  logic [31:0]       pkt_in_cnt;
  logic [31:0]       pkt_cut_cnt;
  logic [31:0]       bytes_dropped_cnt;

  packet_snap_cutter dut (
    .axi_aclk          (axi_aclk),
    .axi_reset         (axi_reset),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tkeep      (s_axis_tkeep),
    .s_axis_tuser      (s_axis_tuser),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tkeep      (m_axis_tkeep),
    .m_axis_tuser      (m_axis_tuser),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .cut_en            (cut_en),
    .snap_len          (snap_len),
    .clr_stats         (clr_stats),
    .pkt_in_cnt        (pkt_in_cnt),
    .pkt_cut_cnt       (pkt_cut_cnt),
    .bytes_dropped_cnt (bytes_dropped_cnt)
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct packed {
    logic [DW-1:0]  d;
    logic [BPB-1:0] k;
    logic [UW-1:0]  u;
    logic           l;
  } beat_t;

  beat_t       exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          out_beats = 0;
  int          snap_cfg[NCH];
  bit          cfg_en = 1'b0;
  bit          hold = 1'b0;
  bit          rnd_rdy = 1'b0;
  logic [31:0] m_in = '0;
  logic [31:0] m_cut = '0;
  logic [31:0] m_drop = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
  endtask

  function automatic logic [BPB-1:0] kmask(input int n);
    logic [BPB-1:0] m;
    m = '0;
    for (int i = 0; i < BPB; i++)
      if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic int eff_snap(input logic [7:0] pm);
    if (!cfg_en) return 0;
    for (int i = 0; i < NCH; i++)
      if (pm[2*i]) return snap_cfg[i];
    return 0;
  endfunction

  task automatic apply_cfg();
    for (int i = 0; i < NCH; i++)
      snap_len[i*LW +: LW] = LW'(snap_cfg[i]);
    cut_en = cfg_en;
  endtask

  always @(posedge axi_aclk) begin
    #1;
    if (hold) m_axis_tready = 1'b0;
    else if (rnd_rdy) m_axis_tready = 1'($urandom_range(0, 1));
    else m_axis_tready = 1'b1;
  end

  // Scoreboard: every output handshake pops one expected beat.
  always @(negedge axi_aclk) begin
    if (!axi_reset && m_axis_tvalid && m_axis_tready) begin
      beat_t e;
      n_tests++;
      out_beats++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_beat: unexpected beat keep=%h last=%b",
                 m_axis_tkeep, m_axis_tlast);
      end else begin
        e = exp_q.pop_front();
        if (m_axis_tdata !== e.d || m_axis_tkeep !== e.k ||
            m_axis_tuser !== e.u || m_axis_tlast !== e.l) begin
          n_fail++;
          $display("FAIL out_beat: got k=%h l=%b u=%h dok=%b, expected k=%h l=%b u=%h",
                   m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                   m_axis_tdata === e.d, e.k, e.l, e.u);
        end
      end
    end
  end

  task automatic check_stats(input string nm);
    chk({nm, "_in"}, pkt_in_cnt, m_in);
    chk({nm, "_cut"}, pkt_cut_cnt, m_cut);
    chk({nm, "_drop"}, bytes_dropped_cnt, m_drop);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 || m_axis_tvalid) begin
      @(negedge axi_aclk);
      w++;
      if (w > 5000) begin
        n_tests++;
        n_fail++;
        $display("FAIL drain_timeout: %0d beats left, expected 0",
                 exp_q.size());
        break;
      end
    end
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic clear_all();
    clr_stats = 1'b1;
    @(posedge axi_aclk);
    #1;
    clr_stats = 1'b0;
    m_in = '0;
    m_cut = '0;
    m_drop = '0;
    out_beats = 0;
  endtask

  // mid: 1 drops cut_en, 2 moves ch0 snap to 150 after the SOP beat.
  task automatic send_pkt(input int len, input logic [7:0] pm,
                          input int mid, input int hold_beat,
                          input int abort_after, input bit clr_sop);
    beat_t ib[$];
    beat_t x;
    int    nb, s, no, waited;
    bit    cut;
    nb = (len + BPB - 1) / BPB;
    for (int b = 0; b < nb; b++) begin
      for (int w = 0; w < DW / 32; w++) x.d[w*32 +: 32] = $urandom;
      x.k = kmask((b == nb - 1) ? len - b * BPB : BPB);
      x.u = {$urandom, $urandom, $urandom, $urandom};
      if (b == 0) begin
        x.u[15:0]  = 16'(len);
        x.u[23:16] = pm;
      end
      x.l = (b == nb - 1);
      ib.push_back(x);
    end
    s = eff_snap(pm);
    cut = (s != 0) && (s < len);
    if (!cut) begin
      foreach (ib[b]) exp_q.push_back(ib[b]);
    end else begin
      no = (s + BPB - 1) / BPB;
      for (int b = 0; b < no; b++) begin
        x = ib[b];
        if (b == no - 1) begin
          x.k = kmask(s - b * BPB);
          x.l = 1'b1;
        end
        if (b == 0) begin
          x.u[15:0] = 16'(s);
          x.u[32]   = 1'b1;
        end
        exp_q.push_back(x);
      end
    end
    m_in = m_in + 32'd1;
    if (cut) begin
      m_cut  = m_cut + 32'd1;
      m_drop = m_drop + 32'(len - s);
    end
    if (clr_sop) begin
      m_in = '0;
      m_cut = '0;
      m_drop = '0;
    end
    for (int k = 0; k < nb; k++) begin
      if (abort_after > 0 && k == abort_after) begin
        axi_reset = 1'b1;
        @(posedge axi_aclk);
        #1;
        axi_reset = 1'b0;
        chk("rst_mid_tvalid", m_axis_tvalid, 0);
        chk("rst_mid_tready", s_axis_tready, 1);
        chk("rst_mid_in_cnt", pkt_in_cnt, 0);
        exp_q.delete();
        m_in = '0;
        m_cut = '0;
        m_drop = '0;
        return;
      end
      s_axis_tdata  = ib[k].d;
      s_axis_tkeep  = ib[k].k;
      s_axis_tuser  = ib[k].u;
      s_axis_tlast  = ib[k].l;
      s_axis_tvalid = 1'b1;
      clr_stats     = clr_sop && (k == 0);
      waited = 0;
      forever begin
        @(negedge axi_aclk);
        if (hold_beat == k && waited == 0) begin
          chk("drop_tready", {m_axis_tready, s_axis_tready}, 2'b01);
          hold = 1'b0;
        end
        if (s_axis_tready) break;
        waited++;
        if (waited > 2000) begin
          n_tests++;
          n_fail++;
          $display("FAIL accept_timeout: beat %0d not accepted", k);
          summary();
          $fatal(1, "input stalled");
        end
      end
      if (hold_beat == k + 1) hold = 1'b1;
      @(posedge axi_aclk);
      #1;
      s_axis_tvalid = 1'b0;
      clr_stats = 1'b0;
      if (k == 0) begin
        if (mid == 1) begin
          cfg_en = 1'b0;
          apply_cfg();
        end
        if (mid == 2) begin
          snap_cfg[0] = 150;
          apply_cfg();
        end
        if (clr_sop) begin
          @(negedge axi_aclk);
          chk("clr_in", pkt_in_cnt, 0);
          chk("clr_cut", pkt_cut_cnt, 0);
          chk("clr_drop", bytes_dropped_cnt, 0);
          @(posedge axi_aclk);
          #1;
        end
      end
    end
  endtask

  initial begin
    axi_reset = 1'b1;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tuser = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    clr_stats = 1'b0;
    for (int i = 0; i < NCH; i++) snap_cfg[i] = 0;
    apply_cfg();
    repeat (3) @(posedge axi_aclk);
    #1;
    axi_reset = 1'b0;
    @(negedge axi_aclk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tkeep", m_axis_tkeep, 0);
    chk("rst_tuser_lo", m_axis_tuser[63:0], 0);
    chk("rst_tready", s_axis_tready, 1);
    check_stats("rst");
    @(posedge axi_aclk);
    #1;

    // 200 bytes cut to 100 on channel 0
    cfg_en = 1'b1;
    snap_cfg[0] = 100;
    apply_cfg();
    send_pkt(200, 8'h01, 0, -1, 0, 1'b0);
    drain();
    chk("t1_out_beats", out_beats, 4);
    chk("t1_cut", pkt_cut_cnt, 1);
    chk("t1_drop", bytes_dropped_cnt, 100);
    chk("t1_in", pkt_in_cnt, 1);

    // 64-byte packet at snap 64 is not cut
    clear_all();
    snap_cfg[0] = 64;
    apply_cfg();
    send_pkt(64, 8'h01, 0, -1, 0, 1'b0);
    drain();
    chk("t2_out_beats", out_beats, 2);
    chk("t2_cut", pkt_cut_cnt, 0);
    chk("t2_in", pkt_in_cnt, 1);

    // 65 bytes at snap 64: third beat swallowed while output stalls
    clear_all();
    send_pkt(65, 8'h01, 0, 2, 0, 1'b0);
    drain();
    chk("t3_out_beats", out_beats, 2);
    chk("t3_drop", bytes_dropped_cnt, 1);
    check_stats("t3");

    // cut_en dropped mid-packet
    clear_all();
    snap_cfg[0] = 100;
    apply_cfg();
    send_pkt(200, 8'h01, 1, -1, 0, 1'b0);
    send_pkt(200, 8'h01, 0, -1, 0, 1'b0);
    drain();
    chk("t4_cut", pkt_cut_cnt, 1);
    chk("t4_drop", bytes_dropped_cnt, 100);
    check_stats("t4");

    // snap_len changed mid-packet
    clear_all();
    cfg_en = 1'b1;
    snap_cfg[0] = 100;
    apply_cfg();
    send_pkt(200, 8'h01, 2, -1, 0, 1'b0);
    send_pkt(200, 8'h01, 0, -1, 0, 1'b0);
    drain();
    chk("t5_cut", pkt_cut_cnt, 2);
    chk("t5_drop", bytes_dropped_cnt, 150);

    // S=1, then clear coinciding with a cut SOP beat
    clear_all();
    snap_cfg[1] = 1;
    apply_cfg();
    send_pkt(80, 8'h04, 0, -1, 0, 1'b0);
    drain();
    chk("t6_drop", bytes_dropped_cnt, 79);
    snap_cfg[0] = 10;
    apply_cfg();
    send_pkt(100, 8'h01, 0, -1, 0, 1'b1);
    drain();
    check_stats("t6");

    // reset mid-packet, then a clean packet
    send_pkt(200, 8'h01, 0, -1, 2, 1'b0);
    send_pkt(100, 8'h00, 0, -1, 0, 1'b0);
    drain();
    chk("t7_in", pkt_in_cnt, 1);
    check_stats("t7");

    // randomized traffic under 50% backpressure
    clear_all();
    snap_cfg[0] = 100;
    snap_cfg[1] = 64;
    snap_cfg[2] = 1;
    snap_cfg[3] = 37;
    rnd_rdy = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      cfg_en = ($urandom_range(0, 9) != 0);
      apply_cfg();
      send_pkt($urandom_range(1, 300), 8'($urandom), 0, -1, 0, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge axi_aclk);
        #1;
      end
    end
    drain();
    check_stats("rnd");

    summary();
    $finish;
  end

endmodule
